// File: rtl/priority_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : priority_scan_seq
// Function : Chunk-serial leading/trailing one finder with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module priority_scan_seq #(
   parameter  int WIDTH  = 32,
   parameter  int CHUNK  = 8,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int POS_W  = $clog2(WIDTH + 1),
   localparam int CNT_W  = $clog2(NCHUNK + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] out_pos,
   output logic             out_zero,
   output logic [CNT_W-1:0] out_cycles
);

   localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CP_W  = $clog2(CHUNK + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] data_q;
   logic             mode_q;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic [POS_W-1:0] pos_q;
   logic             zero_q;
   logic [CHUNK-1:0] chunk;
   logic [CP_W-1:0]  chunk_pos;
   logic             chunk_hit;
   logic             chunk_last;
   logic [POS_W-1:0] hit_pos;

   always_comb begin
      chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IDX_W'(i)) begin
            chunk = data_q[i*CHUNK +: CHUNK];
         end
      end
   end

   // Last assignment wins: ascending sweep keeps the highest bit, descending the lowest.
   always_comb begin
      chunk_pos = '0;
      if (!mode_q) begin
         for (int b = 0; b < CHUNK; b++) begin
            if (chunk[b]) chunk_pos = CP_W'(b + 1);
         end
      end else begin
         for (int b = CHUNK - 1; b >= 0; b--) begin
            if (chunk[b]) chunk_pos = CP_W'(b + 1);
         end
      end
   end

   assign chunk_hit  = |chunk;
   assign chunk_last = mode_q ? (idx == LAST_IDX) : (idx == '0);
   assign hit_pos    = POS_W'(idx) * POS_W'(CHUNK) + POS_W'(chunk_pos);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SCAN;
         end
         SCAN: begin
            if (chunk_hit || chunk_last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         mode_q <= 1'b0;
         idx    <= '0;
         cnt    <= '0;
         pos_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q <= in_data;
                  mode_q <= in_mode;
                  idx    <= in_mode ? '0 : LAST_IDX;
                  cnt    <= '0;
               end
            end
            SCAN: begin
               cnt <= cnt + CNT_W'(1);
               if (chunk_hit) begin
                  pos_q  <= hit_pos;
                  zero_q <= 1'b0;
               end else if (chunk_last) begin
                  pos_q  <= '0;
                  zero_q <= 1'b1;
               end else begin
                  idx <= mode_q ? idx + IDX_W'(1) : idx - IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_pos    = pos_q;
   assign out_zero   = zero_q;
   assign out_cycles = cnt;

endmodule
`default_nettype wire

// File: tb/tb_priority_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_scan_seq
// Function : Vector table, corner sequences and random scoreboard for priority_scan_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_scan_seq;

   localparam int WIDTH  = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int NVEC   = 11;

   typedef struct {
      logic [5:0] pos;
      logic       zero;
      logic [2:0] cycles;
   } exp_t;

   typedef struct {
      logic        mode;
      logic [31:0] data;
      logic [5:0]  pos;
      logic        zero;
      logic [2:0]  cycles;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_pos;
   logic        out_zero;
   logic [2:0]  out_cycles;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   int   rise_cyc = 0;
   logic prev_ov  = 1'b0;
   exp_t sb[$];
   vec_t vecs[NVEC];

   priority_scan_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_mode    (in_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pos    (out_pos),
      .out_zero   (out_zero),
      .out_cycles (out_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Independent reference: whole-word bit search, chunk count from bit index.
   function automatic exp_t model(input logic m, input logic [31:0] d);
      exp_t e;
      int   k;
      k = -1;
      if (!m) begin
         for (int b = 31; b >= 0 && k < 0; b--) if (d[b]) k = b;
      end else begin
         for (int b = 0; b < 32 && k < 0; b++) if (d[b]) k = b;
      end
      if (k < 0) begin
         e.pos = '0; e.zero = 1'b1; e.cycles = 3'(NCHUNK);
      end else begin
         e.pos    = 6'(k + 1);
         e.zero   = 1'b0;
         e.cycles = m ? 3'(k / CHUNK + 1) : 3'(NCHUNK - k / CHUNK);
      end
      return e;
   endfunction

   // Monitor: latency tracking and scoreboard pops at each output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         prev_ov = 1'b0;
      end else begin
         check("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
         if (in_valid && in_ready) acc_cyc = cyc + 1;
         if (out_valid && !prev_ov) rise_cyc = cyc;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result at %0t: got out_pos %0d, expected no result", $time, out_pos);
            end else begin
               e = sb.pop_front();
               check("out_pos",    32'(out_pos),    32'(e.pos));
               check("out_zero",   32'(out_zero),   32'(e.zero));
               check("out_cycles", 32'(out_cycles), 32'(e.cycles));
               check("latency",    32'(rise_cyc - acc_cyc), 32'(e.cycles));
            end
         end
         prev_ov = out_valid;
      end
   end

   task automatic check_reset();
      check("rst_in_ready",   32'(in_ready),   32'd1);
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_out_pos",    32'(out_pos),    32'd0);
      check("rst_out_zero",   32'(out_zero),   32'd0);
      check("rst_out_cycles", 32'(out_cycles), 32'd0);
   endtask

   task automatic send(input logic m, input logic [31:0] d, input exp_t e);
      int t = 0;
      @(posedge clk); #1;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("send_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_mode  = m;
      in_data  = d;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input bit rand_ready);
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(posedge clk); #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         t++;
      end
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      exp_t e;
      logic m;
      logic [31:0] d;
      int t;

      vecs[0]  = '{1'b0, 32'h0000_0100, 6'd9,  1'b0, 3'd3};
      vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 6'd32, 1'b0, 3'd1};
      vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 6'd1,  1'b0, 3'd1};
      vecs[3]  = '{1'b1, 32'h8000_0000, 6'd32, 1'b0, 3'd4};
      vecs[4]  = '{1'b0, 32'h0000_0000, 6'd0,  1'b1, 3'd4};
      vecs[5]  = '{1'b1, 32'h0000_0000, 6'd0,  1'b1, 3'd4};
      vecs[6]  = '{1'b0, 32'h8000_0000, 6'd32, 1'b0, 3'd1};
      vecs[7]  = '{1'b1, 32'h0000_0001, 6'd1,  1'b0, 3'd1};
      vecs[8]  = '{1'b0, 32'h0000_0001, 6'd1,  1'b0, 3'd4};
      vecs[9]  = '{1'b1, 32'h0001_0000, 6'd17, 1'b0, 3'd3};
      vecs[10] = '{1'b0, 32'h00F0_0000, 6'd24, 1'b0, 3'd2};

      rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
      #3;
      check_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         e = '{pos: vecs[i].pos, zero: vecs[i].zero, cycles: vecs[i].cycles};
         send(vecs[i].mode, vecs[i].data, e);
         wait_empty(1'b0);
      end

      // Backpressure: result must hold while stalled, and a request pulse is ignored.
      out_ready = 1'b0;
      send(1'b0, 32'h0000_0100, '{pos: 6'd9, zero: 1'b0, cycles: 3'd3});
      t = 0;
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("bp_reached_done", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin in_valid = 1'b1; in_mode = 1'b1; in_data = 32'hFFFF_FFFF; end
         if (i == 2) in_valid = 1'b0;
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid),  32'd1);
         check("bp_in_ready",  32'(in_ready),   32'd0);
         check("bp_out_pos",   32'(out_pos),    32'd9);
         check("bp_out_zero",  32'(out_zero),   32'd0);
         check("bp_cycles",    32'(out_cycles), 32'd3);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready),  32'd1);
      check("bp_sb_empty",      32'(sb.size()), 32'd0);

      // Reset in the middle of a scan abandons the request.
      send(1'b0, 32'h0000_0001, '{pos: 6'd1, zero: 1'b0, cycles: 3'd4});
      #2 rst_n = 1'b0;
      #1;
      check_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_result_after_reset", 32'(out_valid), 32'd0);
      end
      send(1'b0, 32'h0000_0080, '{pos: 6'd8, zero: 1'b0, cycles: 3'd4});
      wait_empty(1'b0);

      // Random requests with random output stalls against the reference model.
      for (int n = 0; n < 200; n++) begin
         m = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       d = $urandom;
            1:       d = 32'd1 << $urandom_range(0, 31);
            2:       d = '0;
            default: d = $urandom & (32'hFF << (8 * $urandom_range(0, 3)));
         endcase
         send(m, d, model(m, d));
         wait_empty(1'b1);
      end

      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
